// File: rtl/stream_bit_packer.sv
// stream_bit_packer: packs variable-width LSB-aligned beats into dense 16-bit words.
// Ports: clk, reset_n (sync, active-low), s_* upstream stream in, m_* packed stream out.
module stream_bit_packer #(
  parameter bit ZERO_LEN_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] s_tdata,
  input  logic [4:0]  s_tkeep,
  input  logic        s_tlast,
  input  logic        s_tvalid,
  output logic        s_tready,
  output logic [15:0] m_tdata,
  output logic [4:0]  m_tkeep,
  output logic        m_tlast,
  output logic        m_tvalid,
  input  logic        m_tready
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] m_tdata_q, m_tdata_d;
  logic [4:0]  m_tkeep_q, m_tkeep_d;
  logic        m_tlast_q, m_tlast_d;
  logic        m_tvalid_q, m_tvalid_d;

  logic        out_free;
  logic        accept;
  logic [4:0]  k;
  logic [15:0] mask;
  logic [15:0] masked;
  logic [31:0] app;
  logic [4:0]  n;

  logic        ld;
  logic [15:0] ld_data;
  logic [4:0]  ld_keep;
  logic        ld_last;

  assign out_free = !m_tvalid_q || m_tready;
  assign s_tready = reset_n && (state_q == RUN) && out_free;
  assign accept   = s_tvalid && s_tready;

  assign k      = (s_tkeep > 5'd16) ? 5'd16 : s_tkeep;
  assign mask   = k[4] ? 16'hFFFF : ((16'h1 << k) - 16'h1);
  assign masked = s_tdata & mask;
  assign app    = acc_q | ({16'h0, masked} << cnt_q);
  assign n      = {1'b0, cnt_q} + k;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    m_tvalid_d = m_tvalid_q && !m_tready;
    m_tdata_d  = m_tdata_q;
    m_tkeep_d  = m_tkeep_q;
    m_tlast_d  = m_tlast_q;
    ld         = 1'b0;
    ld_data    = 16'h0;
    ld_keep    = 5'd0;
    ld_last    = 1'b0;

    unique case (1'b1)
      (state_q == FLUSH): begin
        // acc/cnt hold the spilled remainder of the packet
        if (out_free) begin
          ld      = 1'b1;
          ld_data = acc_q[15:0];
          ld_keep = {1'b0, cnt_q};
          ld_last = 1'b1;
          acc_d   = 32'h0;
          cnt_d   = 4'd0;
          state_d = RUN;
        end
      end
      accept: begin
        if (!s_tlast) begin
          if (n[4]) begin
            ld      = 1'b1;
            ld_data = app[15:0];
            ld_keep = 5'd16;
            acc_d   = {16'h0, app[31:16]};
            cnt_d   = n[3:0];
          end else begin
            acc_d = app;
            cnt_d = n[3:0];
          end
        end else if (n > 5'd16) begin
          ld      = 1'b1;
          ld_data = app[15:0];
          ld_keep = 5'd16;
          acc_d   = {16'h0, app[31:16]};
          cnt_d   = n[3:0];
          state_d = FLUSH;
        end else begin
          acc_d = 32'h0;
          cnt_d = 4'd0;
          if (n != 5'd0 || ZERO_LEN_EN) begin
            ld      = 1'b1;
            ld_data = app[15:0];
            ld_keep = n;
            ld_last = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (ld) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = ld_data;
      m_tkeep_d  = ld_keep;
      m_tlast_d  = ld_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= RUN;
      acc_q      <= 32'h0;
      cnt_q      <= 4'd0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= 16'h0;
      m_tkeep_q  <= 5'd0;
      m_tlast_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tkeep_q  <= m_tkeep_d;
      m_tlast_q  <= m_tlast_d;
    end
  end

  assign m_tdata  = m_tdata_q;
  assign m_tkeep  = m_tkeep_q;
  assign m_tlast  = m_tlast_q;
  assign m_tvalid = m_tvalid_q;

endmodule

// File: tb/tb_stream_bit_packer.sv
// tb_stream_bit_packer: directed vector bench for stream_bit_packer.
// Drives on negedge, samples on negedge, m_tready mostly held high.
module tb_stream_bit_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] s_tdata;
  logic [4:0]  s_tkeep;
  logic        s_tlast;
  logic        s_tvalid;
  logic        s_tready;
  logic [15:0] m_tdata;
  logic [4:0]  m_tkeep;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready;

  logic        z_s_tready;
  logic [15:0] z_tdata;
  logic [4:0]  z_tkeep;
  logic        z_tlast;
  logic        z_tvalid;

  always #5 clk = ~clk;

  stream_bit_packer dut (
    .clk(clk), .reset_n(reset_n),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tlast(s_tlast), .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .m_tvalid(m_tvalid),
    .m_tready(m_tready)
  );

  stream_bit_packer #(.ZERO_LEN_EN(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tlast(s_tlast), .s_tvalid(s_tvalid),
    .s_tready(z_s_tready),
    .m_tdata(z_tdata), .m_tkeep(z_tkeep),
    .m_tlast(z_tlast), .m_tvalid(z_tvalid),
    .m_tready(m_tready)
  );

  typedef struct {
    logic [15:0] d;
    logic [4:0]  k;
    logic        l;
    logic        v;
    logic [15:0] ed;
    logic [4:0]  ek;
    logic        el;
    logic        zv;
  } vec_t;

  vec_t vecs[13];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic obeat(input string nm, input logic v,
                       input logic [15:0] d, input logic [4:0] k,
                       input logic l);
    if (v)
      chk(nm, {9'h0, m_tvalid, m_tlast, m_tkeep, m_tdata},
          {9'h0, 1'b1, l, k, d});
    else
      chk(nm, {31'h0, m_tvalid}, 32'h0);
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [15:0] d, input logic [4:0] k,
                      input logic l);
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tvalid = 1'b1;
    @(posedge clk);
    #1 s_tvalid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{16'hABCD, 5'd16, 1'b0, 1'b1, 16'hABCD, 5'd16, 1'b0, 1'b1};
    vecs[1]  = '{16'hFFFF, 5'd5,  1'b1, 1'b1, 16'h001F, 5'd5,  1'b1, 1'b1};
    vecs[2]  = '{16'hFFFF, 5'd20, 1'b1, 1'b1, 16'hFFFF, 5'd16, 1'b1, 1'b1};
    vecs[3]  = '{16'h1234, 5'd8,  1'b0, 1'b0, 16'h0000, 5'd0,  1'b0, 1'b0};
    vecs[4]  = '{16'hFF56, 5'd4,  1'b0, 1'b0, 16'h0000, 5'd0,  1'b0, 1'b0};
    vecs[5]  = '{16'hBEEF, 5'd4,  1'b1, 1'b1, 16'hF634, 5'd16, 1'b1, 1'b1};
    vecs[6]  = '{16'h00AA, 5'd3,  1'b1, 1'b1, 16'h0002, 5'd3,  1'b1, 1'b1};
    vecs[7]  = '{16'h0000, 5'd0,  1'b1, 1'b1, 16'h0000, 5'd0,  1'b1, 1'b0};
    vecs[8]  = '{16'h0FFF, 5'd12, 1'b0, 1'b0, 16'h0000, 5'd0,  1'b0, 1'b0};
    vecs[9]  = '{16'hFFAB, 5'd8,  1'b0, 1'b1, 16'hBFFF, 5'd16, 1'b0, 1'b1};
    vecs[10] = '{16'h0003, 5'd2,  1'b1, 1'b1, 16'h003A, 5'd6,  1'b1, 1'b1};
    vecs[11] = '{16'h1234, 5'd0,  1'b0, 1'b0, 16'h0000, 5'd0,  1'b0, 1'b0};
    vecs[12] = '{16'h5555, 5'd0,  1'b1, 1'b1, 16'h0000, 5'd0,  1'b1, 1'b0};

    reset_n  = 1'b0;
    s_tdata  = 16'h0;
    s_tkeep  = 5'd0;
    s_tlast  = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out", {9'h0, m_tvalid, m_tlast, m_tkeep, m_tdata}, 32'h0);
    chk("rst_rdy", {31'h0, s_tready}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_rdy", {31'h0, s_tready}, 32'h1);

    for (int i = 0; i < 13; i++) begin
      send(vecs[i].d, vecs[i].k, vecs[i].l);
      obeat($sformatf("vec%0d", i), vecs[i].v,
            vecs[i].ed, vecs[i].ek, vecs[i].el);
      chk($sformatf("vec%0d_z", i), {31'h0, z_tvalid},
          {31'h0, vecs[i].zv});
    end
    @(negedge clk);

    // spill into FLUSH with free output
    send(16'h03FF, 5'd10, 1'b0);
    obeat("spill_a", 1'b0, 16'h0, 5'd0, 1'b0);
    send(16'h0155, 5'd10, 1'b1);
    obeat("spill_b", 1'b1, 16'h57FF, 5'd16, 1'b0);
    chk("spill_rdy", {31'h0, s_tready}, 32'h0);
    @(negedge clk);
    obeat("spill_c", 1'b1, 16'h0005, 5'd4, 1'b1);
    chk("spill_rdy2", {31'h0, s_tready}, 32'h1);
    @(negedge clk);
    obeat("spill_d", 1'b0, 16'h0, 5'd0, 1'b0);

    // same spill under 5 cycles of backpressure
    m_tready = 1'b0;
    send(16'h03FF, 5'd10, 1'b0);
    send(16'h0155, 5'd10, 1'b1);
    for (int c = 0; c < 5; c++) begin
      obeat($sformatf("bp_hold%0d", c), 1'b1, 16'h57FF, 5'd16, 1'b0);
      chk($sformatf("bp_rdy%0d", c), {31'h0, s_tready}, 32'h0);
      @(negedge clk);
    end
    m_tready = 1'b1;
    @(negedge clk);
    obeat("bp_rem", 1'b1, 16'h0005, 5'd4, 1'b1);
    chk("bp_rdy", {31'h0, s_tready}, 32'h1);
    @(negedge clk);
    obeat("bp_done", 1'b0, 16'h0, 5'd0, 1'b0);

    // reset mid-packet discards partial bits
    send(16'h03FF, 5'd10, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    obeat("mrst_out", 1'b0, 16'h0, 5'd0, 1'b0);
    chk("mrst_rdy", {31'h0, s_tready}, 32'h0);
    reset_n = 1'b1;
    send(16'h1234, 5'd16, 1'b1);
    obeat("mrst_pkt", 1'b1, 16'h1234, 5'd16, 1'b1);
    @(negedge clk);
    obeat("mrst_end", 1'b0, 16'h0, 5'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stream_bit_packer.md
STREAM_BIT_PACKER -- requirements
Module: stream_bit_packer

Interface
REQ-001 SHALL have parameter ZERO_LEN_EN, default 1: 1 = emit a zero-length tlast beat when a packet ends with no pending bits; 0 = drop it.
REQ-002 SHALL have port clk, input, 1: clock; all logic on posedge clk.
REQ-003 SHALL have port reset_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port s_tdata, input, 16: upstream data; valid bits are LSB-aligned.
REQ-005 SHALL have port s_tkeep, input, 5: count of valid LSBs in s_tdata (0..16).
REQ-006 SHALL have port s_tlast, input, 1: last beat of the upstream packet.
REQ-007 SHALL have port s_tvalid, input, 1: upstream beat valid.
REQ-008 SHALL have port s_tready, output, 1: block accepts a beat when s_tvalid and s_tready are both 1.
REQ-009 SHALL have port m_tdata, output, 16: packed output data, LSB-aligned.
REQ-010 SHALL have port m_tkeep, output, 5: count of valid LSBs in m_tdata (0..16).
REQ-011 SHALL have port m_tlast, output, 1: last beat of the output packet.
REQ-012 SHALL have port m_tvalid, output, 1: output beat valid.
REQ-013 SHALL have port m_tready, input, 1: downstream accept.

Function
REQ-014 SHALL concatenate the valid bits of successive accepted beats densely, earlier bits at lower positions, and emit full 16-bit words with m_tkeep=16.
REQ-015 SHALL keep state in a 32-bit accumulator acc and a fill count cnt (0..15 between beats); bits of acc at or above cnt SHALL be 0.
REQ-016 SHALL treat s_tkeep > 16 as 16, and SHALL mask s_tdata bits at or above s_tkeep to 0 before appending.
REQ-017 SHALL append on each accept: acc |= masked_data << cnt; n = cnt + k, where k is the clamped s_tkeep and n ranges 0..31.
REQ-018 SHALL, on accept with s_tlast=0 and n>=16, load {acc[15:0], 16, 0} into the output register, shift acc right by 16, and set cnt = n-16.
REQ-019 SHALL, on accept with s_tlast=0 and n<16, emit nothing and set cnt = n.
REQ-020 SHALL, on accept with s_tlast=1, flush as follows, then set cnt=0 and acc=0:
- n=16: one beat, tkeep 16, tlast 1.
- 0<n<16: one beat, tkeep n, tlast 1.
- n>16: beat {acc[15:0], 16, tlast 0}, then the FLUSH state emits {acc[31:16], n-16, tlast 1}.
- n=0: beat {0x0000, 0, tlast 1} if ZERO_LEN_EN=1, otherwise nothing.
REQ-021 SHALL implement states RUN and FLUSH:
- RUN->FLUSH only per REQ-020 with n>16.
- FLUSH->RUN when the remainder beat is loaded into a free output register.
REQ-022 SHALL drive s_tready = (state==RUN) && (!m_tvalid || m_tready), combinationally from registered state.
REQ-023 SHALL hold a single registered output slot: m_tvalid rises the cycle after the loading accept (latency 1); m_* SHALL be stable while m_tvalid=1 and m_tready=0.
REQ-024 SHALL, when a beat is consumed (m_tready=1) and a new beat is loaded in the same cycle, keep m_tvalid=1 with the new contents and no bubble.
REQ-025 SHALL drive m_tdata bits at or above m_tkeep to 0.
REQ-026 SHALL never drop, duplicate or reorder bits; total output tkeep per packet SHALL equal total clamped input tkeep.

Reset
REQ-027 SHALL, while reset_n=0 at posedge clk, set state=RUN, acc=0, cnt=0, m_tvalid=0, m_tdata=0, m_tkeep=0, m_tlast=0.
REQ-028 SHALL, on reset mid-packet or mid-FLUSH, discard all partial bits; the first beat after reset starts a new packet at cnt=0.
REQ-029 SHALL hold s_tready=0 while reset_n=0.

Verification
REQ-030 Passthrough: s_tkeep=16, s_tdata=0xABCD, tlast 0 -> next cycle m_tdata=0xABCD, m_tkeep=16, m_tlast=0.
REQ-031 Spill: (0x03FF, k=10, tlast 0) then (0x0155, k=10, tlast 1) -> beats (0x57FF, 16, tlast 0) and (0x0005, 4, tlast 1); s_tready=0 during FLUSH.
REQ-032 Short packet and masking: s_tdata=0xFFFF, k=5, tlast 1 -> (0x001F, 5, tlast 1); k=20 behaves as k=16.
REQ-033 Backpressure: hold m_tready=0 for 5 cycles during REQ-031 -> m_* stable, s_tready=0, no loss; release -> identical output sequence.
REQ-034 Zero-length: cnt=0, accept (k=0, tlast 1) -> (0x0000, 0, tlast 1) with ZERO_LEN_EN=1; no beat with ZERO_LEN_EN=0.
REQ-035 Reset mid-packet: accept k=10 (no output), assert reset_n=0 for 1 cycle, then send (0x1234, 16, tlast 1) -> m_tvalid=0 during reset; then (0x1234, 16, tlast 1) only.
